pe_shift_add_mac: RTL and testbench
===================================

# pe_shift_add_mac

Sequential multiply-accumulate controller for the processing element. It time-shares one `RCA` adder between two jobs: the shift-add partial-product loop and the final accumulate. Operand pairs arrive over a valid/ready handshake. The running sum is returned over a second valid/ready handshake. It sits between the PE operand feeder and the PE output collector.

## Interface
- `WIDTH`, default 8, operand width; the adder, product, and accumulator are 2*WIDTH bits.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand pair `a`/`b` is valid.
- `in_ready`  out  1  block can accept an operand pair.
- `a`  in  WIDTH  unsigned multiplicand.
- `b`  in  WIDTH  unsigned multiplier.
- `acc_clr`  in  1  sampled with the accepted pair; the accumulator restarts from 0 for this pair.
- `out_valid`  out  1  `psum` holds the result for the last accepted pair.
- `out_ready`  in  1  consumer takes the result.
- `psum`  out  2*WIDTH  accumulator value.
- `ovf`  out  1  sticky accumulate carry-out.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - MUL: WIDTH iterations.
  - ACC: 1 cycle.
  - DONE: `out_valid`=1.
- IDLE→MUL on `in_valid && in_ready`. At that edge:
  - latch `a_sh` = zero-extended `a`, and `b_sh` = `b`;
  - clear `prod`;
  - latch `clr_q` = `acc_clr`;
  - clear the iteration counter.
- MUL, each cycle:
  - adder x=`prod`, y=`b_sh[0]` ? `a_sh` : 0, cin=0;
  - `prod` takes the adder sum;
  - `a_sh` shifts left 1, `b_sh` shifts right 1;
  - counter increments.
  - Exit to ACC after iteration WIDTH-1.
- Iteration count is fixed regardless of `b` (b=0 still takes WIDTH cycles).
- ACC:
  - adder x = `clr_q` ? 0 : `acc`, y=`prod`;
  - `acc` takes the sum, modulo 2^(2*WIDTH);
  - `ovf` is set if the adder cout=1. When `clr_q`=1, `ovf` is first cleared and then takes cout, which is always 0 in that case.
- DONE→IDLE on `out_ready`.
- `in_valid` outside IDLE is ignored; there is no queuing.
- `psum` is driven by `acc` at all times. It is only meaningful to the consumer while `out_valid`=1.
- Arithmetic width rules:
  - The product of two WIDTH-bit operands never exceeds 2*WIDTH bits, so the MUL adder carry is ignored.
  - Only the ACC carry is observed.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `psum`=0, `ovf`=0, `prod`=0, counter=0.
- Accept at edge T gives:
  - MUL during cycles T+1..T+WIDTH;
  - ACC at T+WIDTH+1;
  - `out_valid`=1 from T+WIDTH+2.
  - Latency is WIDTH+2 cycles (10 for WIDTH=8).
- `out_valid` and `psum` are held stable until the `out_ready` edge. `out_valid` drops in the following cycle.
- `in_ready` rises the cycle after the output handshake. There is no same-cycle output-to-input bypass.
- Minimum throughput is one pair per WIDTH+3 cycles.
- `in_ready` and `out_valid` are decoded from the state register only. They have no combinational path from inputs.
- `rst` asserted in any state, mid-operation included:
  - immediate return to IDLE;
  - `acc`, `ovf`, `prod` cleared;
  - the in-flight pair is discarded and never reported.

## Structure
- Shared package `pe_pkg` holds:
  - the state encoding (IDLE=2'd0, MUL=2'd1, ACC=2'd2, DONE=2'd3);
  - the counter width constant `$clog2(WIDTH)`.
- One sub-module: a single `RCA` instance with the same `WIDTH` as the sole adder.
  - Its x/y inputs are muxed by state.
  - Its cin is tied to 0.
  - No second adder is permitted.

## Test plan
- Reset: assert `rst` mid-cycle asynchronously → `in_ready`=1, `out_valid`=0, `psum`=0, `ovf`=0 immediately. Check this before any clock edge.
- First pair: a=3, b=5, acc_clr=1 accepted at T → `out_valid` at exactly T+10, `psum`=15, `ovf`=0. Then a=0, b=0, acc_clr=1 → `psum`=0 after the full 10 cycles.
- Accumulate: after a clr=1 pair giving 15, send a=255, b=255, acc_clr=0 → `psum`=65040, `ovf`=0.
- Wrap-around: send a=255, b=255, acc_clr=0 again → `psum`=64529, `ovf`=1. A following a=1, b=1, acc_clr=1 → `psum`=1, `ovf`=0.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE while toggling `in_valid` with new operands → `psum` and `out_valid` stable, `in_ready`=0, no pair accepted. `in_ready`=1 one cycle after `out_ready`.
- Reset mid-operation: pulse `rst` at T+4 of a MUL → IDLE, `psum`=0, `out_valid` never asserts for that pair. The next pair a=2, b=7, acc_clr=0 → `psum`=14.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and constants for the shift-add multiply-accumulate processing element.
package pe_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ACC  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Iteration counter width; widened to 1 bit so WIDTH=1 still builds a counter.
    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/pe_shift_add_mac_if.sv
// Operand-in / partial-sum-out handshake bundle between the PE feeder, the MAC and the collector.
interface pe_shift_add_mac_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 acc_clr;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   psum;
    logic                 ovf;

    modport master (
        output in_valid, a, b, acc_clr, out_ready,
        input  in_ready, out_valid, psum, ovf
    );

    modport slave (
        input  in_valid, a, b, acc_clr, out_ready,
        output in_ready, out_valid, psum, ovf
    );
endinterface

// File: rtl/pe_shift_add_mac_rca.sv
// Ripple-carry adder over 2*WIDTH bits; the only adder in the MAC, shared by multiply and accumulate.
module rca #(
    parameter int WIDTH = 8
) (
    input  logic [2*WIDTH-1:0] x,
    input  logic [2*WIDTH-1:0] y,
    input  logic               cin,
    output logic [2*WIDTH-1:0] sum,
    output logic               cout
);
    always_comb begin
        logic c;
        c   = cin;
        sum = '0;
        for (int i = 0; i < 2*WIDTH; i++) begin
            sum[i] = x[i] ^ y[i] ^ c;
            c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        cout = c;
    end
endmodule

// File: rtl/pe_shift_add_mac.sv
// Sequential shift-add multiplier feeding an accumulator, both sharing a single ripple-carry adder.
//
//   state | meaning
//   IDLE  | in_ready=1, waiting for an operand pair
//   MUL   | WIDTH shift-add iterations building prod
//   ACC   | one cycle adding prod into acc (or restarting from 0)
//   DONE  | out_valid=1, psum held until out_ready
module pe_shift_add_mac
    import pe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    pe_shift_add_mac_if.slave     bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    state_t          state;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [PW-1:0]   a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [PW-1:0]   prod;
    logic [PW-1:0]   acc;
    logic            ovf_q;
    logic            clr_q;
    logic [CW-1:0]   cnt;

    logic [PW-1:0]   add_x;
    logic [PW-1:0]   add_y;
    logic [PW-1:0]   add_sum;
    logic            add_cout;

    // The adder serves the partial-product loop in MUL and the accumulate otherwise.
    always_comb begin
        add_x = '0;
        add_y = '0;
        if (state == ST_MUL) begin
            add_x = prod;
            add_y = b_sh[0] ? a_sh : '0;
        end else begin
            add_x = clr_q ? '0 : acc;
            add_y = prod;
        end
    end

    rca #(.WIDTH(WIDTH)) u_rca (
        .x    (add_x),
        .y    (add_y),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_sh        <= '0;
            b_sh        <= '0;
            prod        <= '0;
            acc         <= '0;
            ovf_q       <= 1'b0;
            clr_q       <= 1'b0;
            cnt         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        a_sh       <= {{WIDTH{1'b0}}, bus.a};
                        b_sh       <= bus.b;
                        prod       <= '0;
                        clr_q      <= bus.acc_clr;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    // Product fits in PW bits, so the carry here is meaningless.
                    prod <= add_sum;
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        state <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    acc         <= add_sum;
                    ovf_q       <= clr_q ? add_cout : (ovf_q | add_cout);
                    out_valid_q <= 1'b1;
                    state       <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.psum      = acc;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_pe_shift_add_mac.sv
// Directed bench for pe_shift_add_mac: reset, latency, accumulate, wrap, backpressure, mid-op reset.
module tb_pe_shift_add_mac;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    pe_shift_add_mac_if #(.WIDTH(8)) bus ();

    pe_shift_add_mac #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Presents one pair; returns at the negedge following the accepting edge.
    task automatic start(input logic [7:0] av, input logic [7:0] bv, input logic clr);
        @(negedge clk);
        bus.a        = av;
        bus.b        = bv;
        bus.acc_clr  = clr;
        bus.in_valid = 1'b1;
        check("in_ready_at_offer", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // out_valid must still be low 8 edges after accept and high after the 9th.
    task automatic wait_done(input string tag);
        repeat (8) @(negedge clk);
        check({tag, "_valid_early"}, 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check({tag, "_valid_on_time"}, 32'(bus.out_valid), 32'd1);
    endtask

    task automatic take_out(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_in_ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run_pair(input logic [7:0] av, input logic [7:0] bv, input logic clr,
                            input logic [15:0] exp_psum, input logic exp_ovf, input string tag);
        start(av, bv, clr);
        wait_done(tag);
        check({tag, "_psum"}, 32'(bus.psum), 32'(exp_psum));
        check({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
        take_out(tag);
    endtask

    initial begin
        logic seen_valid;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.acc_clr   = 1'b0;
        bus.out_ready = 1'b0;

        // Asynchronous reset observed before the first rising edge.
        #3 rst = 1'b1;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_psum", 32'(bus.psum), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_pair(8'd3, 8'd5, 1'b1, 16'd15, 1'b0, "first");
        run_pair(8'd0, 8'd0, 1'b1, 16'd0, 1'b0, "zero");

        run_pair(8'd3, 8'd5, 1'b1, 16'd15, 1'b0, "seed");
        run_pair(8'd255, 8'd255, 1'b0, 16'd65040, 1'b0, "accum");
        run_pair(8'd255, 8'd255, 1'b0, 16'd64529, 1'b1, "wrap");
        run_pair(8'd1, 8'd1, 1'b1, 16'd1, 1'b0, "clr_after_wrap");

        // Backpressure: DONE holds while new operands are waved at the input.
        start(8'd3, 8'd5, 1'b1);
        wait_done("bp");
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.a        = 8'(9 + i);
            bus.b        = 8'd9;
            @(negedge clk);
            check("bp_psum_hold", 32'(bus.psum), 32'd15);
            check("bp_valid_hold", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        take_out("bp");
        check("bp_no_accept_psum", 32'(bus.psum), 32'd15);
        @(negedge clk);
        check("bp_still_idle", 32'(bus.in_ready), 32'd1);

        // Reset in the middle of MUL drops the pair entirely.
        start(8'd200, 8'd200, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_psum", 32'(bus.psum), 32'd0);
        check("midrst_ovf", 32'(bus.ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen_valid = seen_valid | bus.out_valid;
        end
        check("midrst_never_valid", 32'(seen_valid), 32'd0);
        run_pair(8'd2, 8'd7, 1'b0, 16'd14, 1'b0, "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
